load_store_queue: RTL and testbench

Parametrised, DEPTH-entry circular load/store queue for the out-of-order core; successor to the single-entry load/store register.
- Allocates entries in program order at dispatch, then fills address and store value out of order, indexed by the slot number returned at allocation.
- Retires in order from the head through a valid/ready handshake.
- Provides a combinational store-to-load forwarding lookup and a full flush.

---
 rtl/lsq_pkg.sv | 25 ++
 rtl/lsq_entry.sv | 49 ++++
 rtl/load_store_queue.sv | 134 +++++++++++++
 tb/tb_load_store_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsq_pkg.sv
// Shared types for the load/store queue: the per-slot payload layout,
// default field widths and the head-relative age helper.
package lsq_pkg;

    localparam int PC_W   = 64;
    localparam int ROB_W  = 5;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    typedef struct packed {
        logic              is_load;
        logic [PC_W-1:0]   pc;
        logic [ROB_W-1:0]  rob;
        logic              addr_ok;
        logic [ADDR_W-1:0] addr;
        logic              val_ok;
        logic [DATA_W-1:0] val;
    } lsq_entry_t;

    // Distance of a slot from the head; 0 is the oldest entry.
    function automatic int unsigned lsq_age(int unsigned idx, int unsigned head, int unsigned depth);
        return (idx + depth - head) % depth;
    endfunction

endpackage

// File: rtl/lsq_entry.sv
// One queue slot: occupancy flag plus payload, with independent enables for
// the dispatch fields, the address and the store value.
module lsq_entry
    import lsq_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              alloc_en,
    input  logic              alloc_is_load,
    input  logic [PC_W-1:0]   alloc_pc,
    input  logic [ROB_W-1:0]  alloc_rob,
    input  logic              addr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic              val_en,
    input  logic [DATA_W-1:0] val,
    input  logic              free,
    output logic              occupied,
    output lsq_entry_t        ent
);

    // Only the flags are cleared; payload is qualified by the flags.
    always_ff @(posedge clk) begin
        if (clr) begin
            occupied    <= 1'b0;
            ent.addr_ok <= 1'b0;
            ent.val_ok  <= 1'b0;
        end else begin
            if (alloc_en) begin
                occupied    <= 1'b1;
                ent.is_load <= alloc_is_load;
                ent.pc      <= alloc_pc;
                ent.rob     <= alloc_rob;
                ent.addr_ok <= 1'b0;
                ent.val_ok  <= 1'b0;
            end else if (free) begin
                occupied <= 1'b0;
            end
            if (addr_en) begin
                ent.addr    <= addr;
                ent.addr_ok <= 1'b1;
            end
            if (val_en) begin
                ent.val    <= val;
                ent.val_ok <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/load_store_queue.sv
// Circular load/store queue: in-order allocate and retire, out-of-order
// address/value fill, and a combinational store-to-load forwarding search.
module load_store_queue
    import lsq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int PC_W   = lsq_pkg::PC_W,
    parameter int ROB_W  = lsq_pkg::ROB_W,
    parameter int ADDR_W = lsq_pkg::ADDR_W,
    parameter int DATA_W = lsq_pkg::DATA_W,
    localparam int IW    = $clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    input  logic              alloc_is_load,
    input  logic [PC_W-1:0]   alloc_pc,
    input  logic [ROB_W-1:0]  alloc_rob,
    output logic              alloc_ready,
    output logic [IW-1:0]     alloc_idx,
    input  logic              addr_valid,
    input  logic [IW-1:0]     addr_idx,
    input  logic [ADDR_W-1:0] addr_data,
    input  logic              val_valid,
    input  logic [IW-1:0]     val_idx,
    input  logic [DATA_W-1:0] val_data,
    output logic              ret_valid,
    input  logic              ret_ready,
    output logic              ret_is_load,
    output logic [PC_W-1:0]   ret_pc,
    output logic [ROB_W-1:0]  ret_rob,
    output logic [ADDR_W-1:0] ret_addr,
    output logic [DATA_W-1:0] ret_val,
    input  logic              flush,
    input  logic [IW-1:0]     fwd_idx,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic              fwd_unknown,
    output logic              fwd_data_valid,
    output logic [DATA_W-1:0] fwd_data,
    output logic [IW:0]       count
);

    localparam int          PKG_PC_W   = lsq_pkg::PC_W;
    localparam int          PKG_ROB_W  = lsq_pkg::ROB_W;
    localparam int          PKG_ADDR_W = lsq_pkg::ADDR_W;
    localparam int          PKG_DATA_W = lsq_pkg::DATA_W;
    localparam logic [IW:0] FULL       = (IW+1)'(DEPTH);

    logic [IW-1:0]    head, tail;
    logic [IW:0]      cnt;
    logic [DEPTH-1:0] occ;
    lsq_entry_t       ent [DEPTH];
    lsq_entry_t       head_ent;
    logic             clr, do_alloc, do_ret;

    assign clr         = reset || flush;
    assign alloc_ready = (cnt != FULL);
    assign alloc_idx   = tail;
    assign count       = cnt;
    assign do_alloc    = alloc_valid && alloc_ready && !flush;
    assign do_ret      = ret_valid && ret_ready && !flush;

    // The tail slot is always free when not full, and writes are gated by
    // start-of-cycle occupancy, so alloc and fill never hit one slot together.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        localparam logic [IW-1:0] SLOT = IW'(i);
        lsq_entry u_entry (
            .clk           (clk),
            .clr           (clr),
            .alloc_en      (do_alloc && tail == SLOT),
            .alloc_is_load (alloc_is_load),
            .alloc_pc      (PKG_PC_W'(alloc_pc)),
            .alloc_rob     (PKG_ROB_W'(alloc_rob)),
            .addr_en       (addr_valid && !flush && addr_idx == SLOT && occ[i]),
            .addr          (PKG_ADDR_W'(addr_data)),
            .val_en        (val_valid && !flush && val_idx == SLOT && occ[i] && !ent[i].is_load),
            .val           (PKG_DATA_W'(val_data)),
            .free          (do_ret && head == SLOT),
            .occupied      (occ[i]),
            .ent           (ent[i])
        );
    end

    assign head_ent    = ent[head];
    assign ret_valid   = occ[head] && head_ent.addr_ok && (head_ent.is_load || head_ent.val_ok);
    assign ret_is_load = head_ent.is_load;
    assign ret_pc      = head_ent.pc[PC_W-1:0];
    assign ret_rob     = head_ent.rob[ROB_W-1:0];
    assign ret_addr    = head_ent.addr[ADDR_W-1:0];
    assign ret_val     = head_ent.is_load ? '0 : head_ent.val[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (do_alloc) tail <= tail + IW'(1);
            if (do_ret)   head <= head + IW'(1);
            if (do_alloc && !do_ret)      cnt <= cnt + (IW+1)'(1);
            else if (!do_alloc && do_ret) cnt <= cnt - (IW+1)'(1);
        end
    end

    // Slots are scanned in index order, so the youngest match is tracked by age.
    logic        q_ok;
    int unsigned q_age, s_age, best_age;

    always_comb begin
        fwd_hit        = 1'b0;
        fwd_unknown    = 1'b0;
        fwd_data_valid = 1'b0;
        fwd_data       = '0;
        best_age       = 0;
        s_age          = 0;
        q_ok           = occ[fwd_idx] && ent[fwd_idx].is_load;
        q_age          = lsq_age(32'(fwd_idx), 32'(head), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            s_age = lsq_age(i, 32'(head), DEPTH);
            if (q_ok && occ[i] && !ent[i].is_load && s_age < q_age) begin
                if (!ent[i].addr_ok) begin
                    fwd_unknown = 1'b1;
                end else if (ent[i].addr[ADDR_W-1:0] == fwd_addr && (!fwd_hit || s_age > best_age)) begin
                    fwd_hit        = 1'b1;
                    best_age       = s_age;
                    fwd_data_valid = ent[i].val_ok;
                    fwd_data       = ent[i].val_ok ? ent[i].val[DATA_W-1:0] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_queue.sv
// Scoreboard bench for load_store_queue: directed scenarios followed by random
// traffic, compared every cycle against a program-order queue model.
module tb_load_store_queue;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        reset, alloc_valid, alloc_is_load, alloc_ready;
    logic [63:0] alloc_pc;
    logic [4:0]  alloc_rob;
    logic [2:0]  alloc_idx, addr_idx, val_idx, fwd_idx;
    logic        addr_valid, val_valid, ret_valid, ret_ready, ret_is_load, flush;
    logic [63:0] addr_data, val_data, ret_pc, ret_addr, ret_val, fwd_addr, fwd_data;
    logic [4:0]  ret_rob;
    logic        fwd_hit, fwd_unknown, fwd_data_valid;
    logic [3:0]  count;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    load_store_queue #(.DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_is_load(alloc_is_load), .alloc_pc(alloc_pc),
        .alloc_rob(alloc_rob), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .addr_valid(addr_valid), .addr_idx(addr_idx), .addr_data(addr_data),
        .val_valid(val_valid), .val_idx(val_idx), .val_data(val_data),
        .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_is_load(ret_is_load),
        .ret_pc(ret_pc), .ret_rob(ret_rob), .ret_addr(ret_addr), .ret_val(ret_val),
        .flush(flush), .fwd_idx(fwd_idx), .fwd_addr(fwd_addr),
        .fwd_hit(fwd_hit), .fwd_unknown(fwd_unknown), .fwd_data_valid(fwd_data_valid),
        .fwd_data(fwd_data), .count(count)
    );

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: entries in program order, each remembering its slot.
    typedef struct {
        bit          ld;
        logic [63:0] pc;
        logic [4:0]  rob;
        bit          aok;
        logic [63:0] addr;
        bit          vok;
        logic [63:0] val;
        int          slot;
    } m_t;

    m_t mq[$];
    int mhead = 0;

    function automatic bit m_rv();
        if (mq.size() == 0) return 1'b0;
        return mq[0].aok && (mq[0].ld || mq[0].vok);
    endfunction

    always @(posedge clk) begin
        int n, tl;
        bit rv;
        m_t e;
        if (reset || flush) begin
            mq.delete();
            mhead = 0;
        end else begin
            n  = mq.size();
            rv = m_rv();
            tl = (mhead + n) % D;
            for (int k = 0; k < n; k++) begin
                e = mq[k];
                if (addr_valid && e.slot == int'(addr_idx)) begin
                    e.aok  = 1'b1;
                    e.addr = addr_data;
                end
                if (val_valid && e.slot == int'(val_idx) && !e.ld) begin
                    e.vok = 1'b1;
                    e.val = val_data;
                end
                mq[k] = e;
            end
            if (rv && ret_ready) begin
                void'(mq.pop_front());
                mhead = (mhead + 1) % D;
            end
            if (alloc_valid && n < D) begin
                e.ld = alloc_is_load; e.pc = alloc_pc; e.rob = alloc_rob;
                e.aok = 1'b0; e.addr = '0; e.vok = 1'b0; e.val = '0; e.slot = tl;
                mq.push_back(e);
            end
        end
    end

    // Monitor: compares DUT outputs against the model every cycle.
    always @(negedge clk) begin
        m_t e;
        int p;
        bit ehit, eunk, edv;
        logic [63:0] edata;
        if (mon_en) begin
            chk("count", 64'(count), 64'(mq.size()));
            chk("alloc_ready", 64'(alloc_ready), 64'(mq.size() < D));
            chk("alloc_idx", 64'(alloc_idx), 64'((mhead + mq.size()) % D));
            chk("ret_valid", 64'(ret_valid), 64'(m_rv()));
            if (m_rv() && ret_ready && !flush) begin
                e = mq[0];
                chk("ret_is_load", 64'(ret_is_load), 64'(e.ld));
                chk("ret_pc", ret_pc, e.pc);
                chk("ret_rob", 64'(ret_rob), 64'(e.rob));
                chk("ret_addr", ret_addr, e.addr);
                chk("ret_val", ret_val, e.ld ? 64'd0 : e.val);
            end
            ehit = 1'b0; eunk = 1'b0; edv = 1'b0; edata = '0; p = -1;
            for (int k = 0; k < mq.size(); k++)
                if (mq[k].slot == int'(fwd_idx)) p = k;
            if (p >= 0 && mq[p].ld) begin
                for (int k = 0; k < p; k++) begin
                    if (!mq[k].ld) begin
                        if (!mq[k].aok) eunk = 1'b1;
                        else if (mq[k].addr == fwd_addr) begin
                            ehit = 1'b1; edv = mq[k].vok; edata = mq[k].vok ? mq[k].val : 64'd0;
                        end
                    end
                end
            end
            chk("fwd_hit", 64'(fwd_hit), 64'(ehit));
            chk("fwd_unknown", 64'(fwd_unknown), 64'(eunk));
            chk("fwd_data_valid", 64'(fwd_data_valid), 64'(edv));
            chk("fwd_data", fwd_data, edata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0; addr_valid = 1'b0; val_valid = 1'b0;
        ret_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1; alloc_is_load = 1'b0; alloc_pc = '0; alloc_rob = '0;
        addr_idx = '0; addr_data = '0; val_idx = '0; val_data = '0;
        fwd_idx = '0; fwd_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;

        chk("rst_count", 64'(count), 64'd0);
        chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("rst_alloc_idx", 64'(alloc_idx), 64'd0);
        chk("rst_ret_valid", 64'(ret_valid), 64'd0);
        chk("rst_fwd", {fwd_hit, fwd_unknown, fwd_data_valid, fwd_data[60:0]}, 64'd0);

        // Fill: S S L S L L L L, then a ninth request that must be ignored.
        for (int i = 0; i < 9; i++) begin
            alloc_valid = 1'b1;
            alloc_is_load = (i == 2 || i >= 4);
            alloc_pc = 64'h1000 + 64'(4 * i);
            alloc_rob = 5'(i);
            chk("fill_alloc_idx", 64'(alloc_idx), 64'(i % 8));
            step();
        end
        alloc_valid = 1'b0;
        chk("full_count", 64'(count), 64'd8);
        chk("full_alloc_ready", 64'(alloc_ready), 64'd0);

        // Head store becomes retireable only once its value arrives.
        addr_valid = 1'b1; addr_idx = 3'd0; addr_data = 64'h100;
        step();
        addr_valid = 1'b0;
        chk("addr_only_ret_valid", 64'(ret_valid), 64'd0);
        val_valid = 1'b1; val_idx = 3'd0; val_data = 64'hAB;
        step();
        val_valid = 1'b0;
        chk("store_ret_valid", 64'(ret_valid), 64'd1);
        chk("store_ret_addr", ret_addr, 64'h100);
        chk("store_ret_val", ret_val, 64'hAB);

        // Retire while full plus an alloc: alloc refused, then taken at slot 0.
        ret_ready = 1'b1; alloc_valid = 1'b1; alloc_is_load = 1'b1; alloc_pc = 64'h2000; alloc_rob = 5'd20;
        step();
        ret_ready = 1'b0;
        chk("ret_full_count", 64'(count), 64'd7);
        chk("ret_full_alloc_idx", 64'(alloc_idx), 64'd0);
        step();
        alloc_valid = 1'b0;
        chk("wrap_count", 64'(count), 64'd8);
        chk("wrap_alloc_idx", 64'(alloc_idx), 64'd1);

        // Older store without an address blocks the load at slot 2.
        fwd_idx = 3'd2; fwd_addr = 64'h40;
        #1;
        chk("unk_fwd_unknown", 64'(fwd_unknown), 64'd1);
        chk("unk_fwd_hit", 64'(fwd_hit), 64'd0);

        addr_valid = 1'b1; addr_idx = 3'd1; addr_data = 64'h40;
        val_valid = 1'b1; val_idx = 3'd1; val_data = 64'h11;
        step();
        addr_idx = 3'd3; val_idx = 3'd3; val_data = 64'h33;
        step();
        idle();
        fwd_idx = 3'd4;
        #1;
        chk("fwd4_hit", 64'(fwd_hit), 64'd1);
        chk("fwd4_data", fwd_data, 64'h33);
        fwd_idx = 3'd2;
        #1;
        chk("fwd2_hit", 64'(fwd_hit), 64'd1);
        chk("fwd2_data", fwd_data, 64'h11);

        // Flush five entries with a concurrent alloc and address write.
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            alloc_valid = 1'b1; alloc_is_load = i[0]; alloc_pc = 64'h3000 + 64'(i); alloc_rob = 5'(i);
            step();
        end
        chk("pre_flush_count", 64'(count), 64'd5);
        flush = 1'b1; addr_valid = 1'b1; addr_idx = 3'd1; addr_data = 64'h80;
        step();
        idle();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_ret_valid", 64'(ret_valid), 64'd0);
        chk("flush_alloc_idx", 64'(alloc_idx), 64'd0);

        // Random traffic over a small address set so forwarding hits are common.
        for (int c = 0; c < 3000; c++) begin
            alloc_valid   = $urandom_range(0, 99) < 60;
            alloc_is_load = 1'($urandom_range(0, 1));
            alloc_pc      = {$urandom, $urandom};
            alloc_rob     = 5'($urandom);
            addr_valid    = $urandom_range(0, 99) < 50;
            addr_idx      = 3'($urandom);
            addr_data     = 64'h40 * 64'($urandom_range(1, 3));
            val_valid     = $urandom_range(0, 99) < 50;
            val_idx       = 3'($urandom);
            val_data      = {$urandom, $urandom};
            ret_ready     = $urandom_range(0, 99) < 40;
            flush         = $urandom_range(0, 199) == 0;
            fwd_idx       = 3'($urandom);
            fwd_addr      = 64'h40 * 64'($urandom_range(1, 3));
            step();
        end
        idle();
        repeat (2) step();
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
